apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort (>=2).
REQ-005 SHALL use one clock and an asynchronous active-low reset: PCLK input 1, PRESETn input 1.
REQ-006 SHALL have req_transfer input NREQ: per-requester transfer request, held high until done.
REQ-007 SHALL have req_write input NREQ: 1=write, 0=read.
REQ-008 SHALL have req_addr input NREQ*AW: flattened, requester i at [i*AW +: AW].
REQ-009 SHALL have req_wdata input NREQ*DW: flattened write data.
REQ-010 SHALL have req_strb input NREQ*(DW/8): flattened byte strobes.
REQ-011 SHALL have req_prot input NREQ*3: flattened protection.
REQ-012 SHALL have req_done output NREQ: one-cycle completion pulse, one-hot.
REQ-013 SHALL have rdata output DW: read data, valid while req_done is nonzero.
REQ-014 SHALL have error output 1: PSLVERR or timeout, valid while req_done is nonzero.
REQ-015 SHALL have the APB master ports PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT (outputs) and PRDATA, PREADY, PSLVERR (inputs), with AMBA APB4 widths.

Function
REQ-016 SHALL sequence the APB bus with states IDLE, SETUP, ACCESS.
- IDLE: PSELx=0, PENABLE=0.
- SETUP: PSELx=1, PENABLE=0.
- ACCESS: PSELx=1, PENABLE=1.
REQ-017 SHALL arbitrate round-robin among eligible requests in IDLE, or at ACCESS completion. Search starts at last_grant+1 modulo NREQ.
REQ-018 SHALL latch the winner's write, addr, wdata, strb and prot at the grant edge. APB outputs SHALL be driven from these registers, stable from SETUP through ACCESS completion.
REQ-019 SHALL go IDLE->SETUP on the edge where any request is eligible, so PSELx rises 1 cycle after req_transfer is sampled.
REQ-020 SHALL go SETUP->ACCESS unconditionally after one cycle.
REQ-021 SHALL complete in ACCESS on the edge where PREADY=1. At that edge: capture PRDATA into rdata and PSLVERR into error, and go to SETUP if another request is eligible, else IDLE.
REQ-022 SHALL count consecutive ACCESS cycles with PREADY=0. When the count reaches TIMEOUT, complete with error=1, rdata=0, and leave the state exactly as in REQ-021.
REQ-023 SHALL pulse req_done[g] for exactly the cycle after completion, with rdata/error valid in that cycle.
REQ-024 SHALL ignore req_transfer[g] for arbitration at the completion edge and during the req_done[g] cycle, so a requester that is still high is not re-granted in that cycle.
REQ-025 SHALL ignore changes to requester inputs after grant. Dropping req_transfer mid-transfer SHALL NOT abort the APB transfer, and req_done SHALL still pulse.
REQ-026 SHALL produce a read with PSLVERR=1 that gives error=1 and rdata=PRDATA.
REQ-027 SHALL update last_grant only on grant.

Reset
REQ-028 SHALL, while PRESETn=0, force:
- state=IDLE;
- PSELx=0, PENABLE=0;
- PADDR, PWDATA, PSTRB, PPROT, PWRITE=0;
- req_done=0, rdata=0, error=0;
- timeout counter=0;
- last_grant=NREQ-1, so requester 0 has first priority.
REQ-029 SHALL abandon an in-flight transfer on reset assertion mid-transfer, with no req_done. After release, arbitration restarts from requester 0.

Structure
REQ-030 SHALL take the state enum (IDLE/SETUP/ACCESS) and the timeout counter width function ($clog2(TIMEOUT+1)) from package apb_arb_pkg.
REQ-031 SHALL put the round-robin selection (request vector, mask, last_grant in; one-hot grant and index out) in combinational sub-module apb_rr_arbiter.

Verification
REQ-032 Single write, NREQ=4: req_transfer=0001, addr=0x10, wdata=0xA5A5A5A5, strb=0xF, slave PREADY=1 immediately -> PSELx high 1 cycle later, PENABLE 1 cycle after that, req_done=0001 one cycle after the ACCESS edge, error=0.
REQ-033 Contention: req_transfer=1111 held through each done -> grant order 0,1,2,3,0. Back-to-back transfers SHALL go ACCESS->SETUP with PSELx never dropping.
REQ-034 Wait states: read by requester 2, PREADY low for 3 ACCESS cycles then high with PRDATA=0xDEADBEEF -> req_done=0100, rdata=0xDEADBEEF, error=0.
REQ-035 Timeout: TIMEOUT=16, PREADY held 0 -> completion after 16 ACCESS cycles with req_done pulse, error=1, rdata=0, then IDLE.
REQ-036 Slave error: write with PSLVERR=1 at PREADY -> error=1.
REQ-037 Reset mid-ACCESS: PRESETn low during ACCESS -> all outputs 0 immediately, no req_done; after release with req_transfer=1010, requester 1 is granted first.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  // APB bus phase of the single shared master port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Width needed for a counter that must hold values 0..timeout.
  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after last_grant.
module apb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  logic [NREQ-1:0] eligible;
  logic [IW-1:0]   idx;
  logic            found;

  assign eligible    = req & ~mask;
  assign grant_valid = |eligible;

  // Walk the requesters starting one past the previous winner, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Multi-requester APB4 master: round-robin grant, one transfer at a time,
// with a wait-state timeout that aborts a hung slave access.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | bus quiet, arbitrate every cycle
// ST_SETUP  | PSELx high, latched request on the bus for one cycle
// ST_ACCESS | PENABLE high, wait for PREADY or timeout; re-arbitrate
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req_transfer,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*(DW/8)-1:0] req_strb,
  input  logic [NREQ*3-1:0]      req_prot,
  output logic [NREQ-1:0]        req_done,
  output logic [DW-1:0]          rdata,
  output logic                   error,
  output logic                   PSELx,
  output logic                   PENABLE,
  output logic [AW-1:0]          PADDR,
  output logic                   PWRITE,
  output logic [DW-1:0]          PWDATA,
  output logic [DW/8-1:0]        PSTRB,
  output logic [2:0]             PPROT,
  input  logic [DW-1:0]          PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DW / 8;
  localparam int TW = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT - 1);

  apb_state_e      state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   cur;
  logic [NREQ-1:0] cur_oh;
  logic [NREQ-1:0] arb_mask;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;
  logic [TW-1:0]   tcnt;
  logic            timed_out;
  logic            complete;
  logic            take_grant;

  assign cur_oh = NREQ'(1) << cur;

  // The requester being served is excluded at its completion edge; during its
  // done cycle the registered done pulse itself provides the exclusion.
  assign arb_mask = (state == ST_ACCESS) ? cur_oh : req_done;

  assign timed_out = (state == ST_ACCESS) && !PREADY && (tcnt == TC_LAST);
  assign complete  = (state == ST_ACCESS) && (PREADY || timed_out);

  assign PSELx   = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE = (state == ST_ACCESS);

  apb_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req         (req_transfer),
    .mask        (arb_mask),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Bus phase register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next phase; a grant is taken from IDLE or straight out of a completing ACCESS.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt  = ST_SETUP;
          take_grant = 1'b1;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (complete) begin
          if (grant_valid) begin
            state_nxt  = ST_SETUP;
            take_grant = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's request so later requester activity cannot disturb the bus.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant <= IW'(NREQ - 1);
      cur        <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PPROT      <= '0;
    end else if (take_grant) begin
      last_grant <= grant_idx;
      cur        <= grant_idx;
      PWRITE     <= req_write[grant_idx];
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          PADDR  <= req_addr[i*AW +: AW];
          PWDATA <= req_wdata[i*DW +: DW];
          PSTRB  <= req_strb[i*SW +: SW];
          PPROT  <= req_prot[i*3 +: 3];
        end
      end
    end
  end

  // Completion pulse and response capture; a timeout reports error with zero data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_done <= '0;
      rdata    <= '0;
      error    <= 1'b0;
    end else begin
      req_done <= complete ? cur_oh : '0;
      if (complete) begin
        rdata <= PREADY ? PRDATA : '0;
        error <= PREADY ? PSLVERR : 1'b1;
      end
    end
  end

  // Consecutive not-ready ACCESS cycles; cleared whenever the access ends.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt <= '0;
    end else if ((state == ST_ACCESS) && !PREADY && !timed_out) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vectors, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_apb_master_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic                 PCLK = 1'b0;
  logic                 PRESETn = 1'b0;
  logic [NREQ-1:0]      req_transfer;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_strb;
  logic [NREQ*3-1:0]    req_prot;
  logic [NREQ-1:0]      req_done;
  logic [DW-1:0]        rdata;
  logic                 error;
  logic                 PSELx, PENABLE, PWRITE;
  logic [AW-1:0]        PADDR;
  logic [DW-1:0]        PWDATA;
  logic [SW-1:0]        PSTRB;
  logic [2:0]           PPROT;
  logic [DW-1:0]        PRDATA;
  logic                 PREADY, PSLVERR;

  apb_master_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_transfer(req_transfer), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_done(req_done), .rdata(rdata), .error(error),
    .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic             r_write [NREQ];
  logic [AW-1:0]    r_addr  [NREQ];
  logic [DW-1:0]    r_wdata [NREQ];
  logic [SW-1:0]    r_strb  [NREQ];
  logic [2:0]       r_prot  [NREQ];

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;     // -1: slave never ready
    logic          slverr;
    logic [DW-1:0] prdata;
    int            exp_acc;   // ACCESS cycles before done
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] elig);
    for (int k = 1; k <= NREQ; k++) begin
      if (elig[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]            = r_write[i];
      req_addr[i*AW +: AW]    = r_addr[i];
      req_wdata[i*DW +: DW]   = r_wdata[i];
      req_strb[i*SW +: SW]    = r_strb[i];
      req_prot[i*3 +: 3]      = r_prot[i];
    end
  endtask

  task automatic rand_attr(input int i);
    r_write[i] = 1'($urandom_range(0, 1));
    r_addr[i]  = $urandom;
    r_wdata[i] = $urandom;
    r_strb[i]  = SW'($urandom);
    r_prot[i]  = 3'($urandom);
  endtask

  task automatic check_bus(input string tag, input int i);
    chk({tag, "_paddr"},  PADDR,  r_addr[i]);
    chk({tag, "_pwrite"}, PWRITE, r_write[i]);
    chk({tag, "_pwdata"}, PWDATA, r_wdata[i]);
    chk({tag, "_pstrb"},  PSTRB,  r_strb[i]);
    chk({tag, "_pprot"},  PPROT,  r_prot[i]);
  endtask

  // Let any in-flight transfer finish with a ready slave, then leave the bus idle.
  task automatic drain();
    req_transfer = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      PREADY  = PSELx && PENABLE;
      PSLVERR = 1'b0;
      if (!PSELx && req_done == '0) break;
    end
    PREADY = 1'b0;
    chk("drain_idle", PSELx, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int n_acc;
    bit seen;
    r_write[v.idx] = v.wr;   r_addr[v.idx] = v.addr; r_wdata[v.idx] = v.wdata;
    r_strb[v.idx]  = v.strb; r_prot[v.idx] = v.prot;
    drive_reqs();
    req_transfer = '0;
    req_transfer[v.idx] = 1'b1;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    tick();
    chk("vec_setup", {PSELx, PENABLE}, 2'b10);
    check_bus("vec_setup", v.idx);
    n_acc = 0;
    seen  = 0;
    for (int c = 0; c < TIMEOUT + 8 && !seen; c++) begin
      tick();
      if (req_done != '0) begin
        seen = 1;
        chk("vec_acc_cycles", n_acc, v.exp_acc);
        chk("vec_done", req_done, oh(v.idx));
        chk("vec_rdata", rdata, v.exp_rdata);
        chk("vec_error", error, v.exp_err);
        chk("vec_done_idle", PSELx, 1'b0);
      end else begin
        chk("vec_access", {PSELx, PENABLE}, 2'b11);
        check_bus("vec_access", v.idx);
        n_acc++;
        PREADY  = (v.waits >= 0) && (n_acc > v.waits);
        PRDATA  = v.prdata;
        PSLVERR = PREADY ? v.slverr : 1'b0;
      end
    end
    chk("vec_done_seen", seen, 1'b1);
    PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    chk("vec_no_regrant", PSELx, 1'b0);
    chk("vec_done_one_cycle", req_done, '0);
    req_transfer = '0;
    tick();
    chk("vec_idle", PSELx, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, owner, last_w, win, n_acc, waits_cur, rsel;
    bit started, psel_drop;
    bit pv_idle, pv_setup, pv_access, pv_complete, exp_setup, exp_access;
    bit busy [NREQ];
    logic [NREQ-1:0] pv_req, pv_done, excl, elig, exp_done;
    logic [DW-1:0] pv_rd;
    logic pv_err;
    logic [AW-1:0] o_addr; logic o_write; logic [DW-1:0] o_wdata;
    logic [SW-1:0] o_strb; logic [2:0] o_prot;
    int exp_order [5];

    vecs[0] = '{idx:0, wr:1'b1, addr:32'h10,  wdata:32'hA5A5A5A5, strb:4'hF, prot:3'd0, waits:0,  slverr:1'b0, prdata:32'h0,        exp_acc:1,  exp_rdata:32'h0,        exp_err:1'b0};
    vecs[1] = '{idx:2, wr:1'b0, addr:32'h200, wdata:32'h0,        strb:4'hF, prot:3'd0, waits:3,  slverr:1'b0, prdata:32'hDEADBEEF, exp_acc:4,  exp_rdata:32'hDEADBEEF, exp_err:1'b0};
    vecs[2] = '{idx:1, wr:1'b1, addr:32'h44,  wdata:32'h12345678, strb:4'h3, prot:3'd5, waits:1,  slverr:1'b1, prdata:32'h0,        exp_acc:2,  exp_rdata:32'h0,        exp_err:1'b1};
    vecs[3] = '{idx:3, wr:1'b0, addr:32'h80,  wdata:32'h0,        strb:4'hF, prot:3'd2, waits:0,  slverr:1'b1, prdata:32'hCAFEF00D, exp_acc:1,  exp_rdata:32'hCAFEF00D, exp_err:1'b1};
    vecs[4] = '{idx:0, wr:1'b0, addr:32'h20,  wdata:32'h0,        strb:4'hF, prot:3'd0, waits:-1, slverr:1'b0, prdata:32'h11111111, exp_acc:16, exp_rdata:32'h0,        exp_err:1'b1};
    vecs[5] = '{idx:1, wr:1'b0, addr:32'h24,  wdata:32'h0,        strb:4'hF, prot:3'd1, waits:15, slverr:1'b0, prdata:32'h0BADF00D, exp_acc:16, exp_rdata:32'h0BADF00D, exp_err:1'b0};

    // Reset values, with requests pending while reset is held.
    req_transfer = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_write[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0; r_prot[i] = '0;
    end
    drive_reqs();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (2) tick();
    chk("rst_psel", PSELx, 1'b0);    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr", PADDR, '0);     chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_pwdata", PWDATA, '0);   chk("rst_pstrb", PSTRB, '0);
    chk("rst_pprot", PPROT, '0);     chk("rst_done", req_done, '0);
    chk("rst_rdata", rdata, '0);     chk("rst_error", error, 1'b0);
    for (int i = 0; i < NREQ; i++) rand_attr(i);
    drive_reqs();
    req_transfer = '1;
    tick();
    chk("rst_psel_held", PSELx, 1'b0);
    PRESETn = 1'b1;

    // Contention: all four held high, zero wait states.
    exp_order = '{0, 1, 2, 3, 0};
    k = 0; started = 0; psel_drop = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      tick();
      if (PSELx) started = 1;
      else if (started) psel_drop = 1;
      PREADY = PSELx && PENABLE;
      if (req_done != '0) begin
        chk($sformatf("rr_order_%0d", k), req_done, oh(exp_order[k]));
        k++;
      end
    end
    chk("rr_done_count", k, 5);
    chk("rr_psel_held", psel_drop, 1'b0);
    drain();

    // Directed single transfers.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Requester drops request and scrambles inputs after grant.
    rand_attr(2);
    drive_reqs();
    req_transfer = 4'b0100;
    tick();
    chk("drop_setup", {PSELx, PENABLE}, 2'b10);
    o_addr = r_addr[2]; o_wdata = r_wdata[2];
    req_transfer = '0;
    r_addr[2] = ~o_addr; r_wdata[2] = ~o_wdata;
    drive_reqs();
    tick();
    chk("drop_access", {PSELx, PENABLE}, 2'b11);
    chk("drop_paddr", PADDR, o_addr);
    chk("drop_pwdata", PWDATA, o_wdata);
    PREADY = 1'b1; PRDATA = 32'h13579BDF; PSLVERR = 1'b0;
    tick();
    chk("drop_done", req_done, 4'b0100);
    chk("drop_rdata", rdata, 32'h13579BDF);
    PREADY = 1'b0;
    tick();
    chk("drop_idle", PSELx, 1'b0);

    // Reset asserted mid-ACCESS.
    rand_attr(0); rand_attr(1);
    r_addr[0] = 32'hFFFF_0000; r_wdata[0] = 32'hFFFF_FFFF; r_strb[0] = 4'hF;
    r_prot[0] = 3'd7; r_write[0] = 1'b1;
    drive_reqs();
    req_transfer = 4'b0001;
    tick();
    tick();
    chk("rstmid_in_access", {PSELx, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid_psel", PSELx, 1'b0);   chk("rstmid_penable", PENABLE, 1'b0);
    chk("rstmid_paddr", PADDR, '0);    chk("rstmid_pwrite", PWRITE, 1'b0);
    chk("rstmid_pwdata", PWDATA, '0);  chk("rstmid_pstrb", PSTRB, '0);
    chk("rstmid_pprot", PPROT, '0);    chk("rstmid_done", req_done, '0);
    chk("rstmid_rdata", rdata, '0);    chk("rstmid_error", error, 1'b0);
    req_transfer = 4'b1010;
    PREADY = 1'b1;
    tick();
    tick();
    chk("rstmid_no_done", req_done, '0);
    PREADY = 1'b0;
    PRESETn = 1'b1;
    tick();
    chk("rstmid_regrant", {PSELx, PENABLE}, 2'b10);
    check_bus("rstmid_regrant", 1);
    drain();

    // Randomized traffic against a transaction-level model.
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin busy[i] = 0; rand_attr(i); end
    drive_reqs();
    req_transfer = '0;
    pv_idle = 1; pv_setup = 0; pv_access = 0; pv_complete = 0;
    pv_req = '0; pv_done = '0; pv_rd = '0; pv_err = 1'b0;
    last_w = NREQ - 1; owner = -1; n_acc = 0; waits_cur = 0;
    o_addr = '0; o_write = 1'b0; o_wdata = '0; o_strb = '0; o_prot = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      exp_setup = 0; exp_access = 0; win = -1;
      exp_done = pv_complete ? oh(owner) : '0;
      if (pv_setup || (pv_access && !pv_complete)) begin
        exp_access = 1;
      end else if (pv_idle || pv_complete) begin
        excl = pv_complete ? oh(owner) : pv_done;
        elig = pv_req & ~excl;
        if (elig != '0) begin
          exp_setup = 1;
          win = rr_pick(last_w, elig);
        end
      end
      chk("rnd_state", {PSELx, PENABLE}, {exp_setup | exp_access, exp_access});
      chk("rnd_done", req_done, exp_done);
      if (exp_done != '0) begin
        chk("rnd_rdata", rdata, pv_rd);
        chk("rnd_error", error, pv_err);
        busy[owner] = 0;
      end
      if (exp_setup) begin
        owner = win; last_w = win; busy[win] = 1; n_acc = 0;
        o_addr = r_addr[win]; o_write = r_write[win]; o_wdata = r_wdata[win];
        o_strb = r_strb[win]; o_prot = r_prot[win];
        rsel = $urandom_range(0, 15);
        waits_cur = (rsel == 0) ? 30 : (rsel == 1) ? 15 : $urandom_range(0, 3);
      end
      if ((exp_setup || exp_access) && owner >= 0) begin
        chk("rnd_paddr", PADDR, o_addr);
        chk("rnd_pwrite", PWRITE, o_write);
        chk("rnd_pwdata", PWDATA, o_wdata);
        chk("rnd_pstrb", PSTRB, o_strb);
        chk("rnd_pprot", PPROT, o_prot);
      end
      pv_complete = 0;
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 7) == 0);
      if (exp_access) begin
        n_acc++;
        PREADY = (n_acc > waits_cur);
        pv_complete = PREADY || (n_acc == TIMEOUT);
        pv_rd  = PREADY ? PRDATA : '0;
        pv_err = PREADY ? PSLVERR : 1'b1;
      end else begin
        PREADY = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp_done[i]) begin
          if ($urandom_range(0, 1) == 0) req_transfer[i] = 1'b0;
        end else if (busy[i]) begin
          if (req_transfer[i] && $urandom_range(0, 15) == 0) begin
            req_transfer[i] = 1'b0;
            r_addr[i]  = $urandom;
            r_wdata[i] = $urandom;
          end
        end else if (!req_transfer[i] && $urandom_range(0, 3) == 0) begin
          rand_attr(i);
          req_transfer[i] = 1'b1;
        end
      end
      drive_reqs();
      pv_req = req_transfer; pv_done = exp_done;
      pv_setup = exp_setup; pv_access = exp_access;
      pv_idle = !exp_setup && !exp_access;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
